// File: rtl/booth_mult_seq.sv
// Sequencer for the signed radix-2 Booth multiplier used by MULT.
// It performs one add/shift per clock and publishes {hi, lo} with a one-cycle done pulse.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    s_q, s_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   m_ext_s;
  logic [WIDTH:0]   m_neg_s;
  logic [PW-1:0]    p_sum_s;
  logic [PW-1:0]    p_step_s;
  logic             load_s;

  // Extending the multiplicand by one bit keeps -2^(WIDTH-1) representable once negated.
  always_comb begin
    m_ext_s = {operand1[WIDTH-1], operand1};
    m_neg_s = ~m_ext_s + {{WIDTH{1'b0}}, 1'b1};
    load_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // One Booth step: add A or S depending on the bit pair, then arithmetic shift right.
  always_comb begin
    case (p_q[1:0])
      2'b01:   p_sum_s = p_q + a_q;
      2'b10:   p_sum_s = p_q + s_q;
      default: p_sum_s = p_q;
    endcase
    p_step_s = {p_sum_s[PW-1], p_sum_s[PW-1:1]};
  end

  // Next-state and datapath register selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    s_d     = s_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (load_s) begin
      a_d     = {m_ext_s, {(WIDTH + 1){1'b0}}};
      s_d     = {m_neg_s, {(WIDTH + 1){1'b0}}};
      p_d     = {{(WIDTH + 1){1'b0}}, operand2, 1'b0};
      cnt_d   = {CNT_W{1'b0}};
      busy_d  = 1'b1;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          p_d   = p_step_s;
          cnt_d = cnt_q + CNT_W'(1);
          // The final step lands the product straight from the stepped P.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = p_step_s[2*WIDTH:WIDTH+1];
            lo_d    = p_step_s[WIDTH:1];
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: begin
          busy_d  = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything including hi/lo.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      a_q     <= {PW{1'b0}};
      s_q     <= {PW{1'b0}};
      p_q     <= {PW{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      s_q     <= s_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: cycle model built on plain signed multiplication,
// directed literal cases from the test plan, plus randomized multiplies.
module tb_booth_mult_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] operand1 = 32'd0;
  logic [31:0] operand2 = 32'd0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int dut_done_cnt = 0;

  // Reference model state
  int          m_remain = 0;
  logic [63:0] m_pend   = 64'd0;
  logic [63:0] m_prod   = 64'd0;
  logic        m_done   = 1'b0;

  booth_mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start),
    .operand1(operand1), .operand2(operand2),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
    longint a, b;
    a = $signed(x);
    b = $signed(y);
    return 64'(a * b);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a multiply takes 32 cycles; a new one is accepted only when nothing is running.
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_remain = 0;
        m_prod   = 64'd0;
        m_done   = 1'b0;
      end else begin
        m_done = 1'b0;
        if (m_remain > 0) begin
          m_remain--;
          if (m_remain == 0) begin
            m_prod = m_pend;
            m_done = 1'b1;
          end
        end else if (start) begin
          m_pend   = smul(operand1, operand2);
          m_remain = 32;
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      check("busy", {63'd0, busy}, {63'd0, (m_remain > 0)});
      check("stall", {63'd0, stall}, {63'd0, (m_remain > 0)});
      check("done", {63'd0, done}, {63'd0, m_done});
      check("hilo", {hi, lo}, m_prod);
      if (done && busy) check("done_and_busy", 64'd1, 64'd0);
      if (done) dut_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for done (bounded); returns the number of ticks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    operand1 = a;
    operand2 = b;
    tick();
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
  endtask

  task automatic mult_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    int n;
    issue(a, b);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'd32);
    check(name, {hi, lo}, exp);
    tick();
    check({name, "_done_fall"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int d0;
    tick();
    tick();
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy", {62'd0, busy, done}, 64'd0);
    reset = 1'b1;
    tick();

    mult_lit("basic_3x5", 32'd3, 32'd5, 64'h00000000_0000000F);
    mult_lit("signed_7xm3", 32'd7, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB);
    mult_lit("signed_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    mult_lit("corner_min_sq", 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    mult_lit("corner_min_x1", 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);

    // start during RUN is ignored
    d0 = dut_done_cnt;
    issue(32'd3, 32'd5);
    repeat (9) tick();
    issue(32'd9, 32'd9);
    wait_done(n);
    check("run_start_latency", 64'(n + 10), 64'd32);
    check("run_start_lo", {hi, lo}, 64'd15);
    repeat (40) tick();
    check("run_start_one_done", 64'(dut_done_cnt - d0), 64'd1);

    // back-to-back: start held through DONE
    start    = 1'b1;
    operand1 = 32'd2;
    operand2 = 32'd2;
    tick();
    wait_done(n);
    check("b2b_first_lat", 64'(n), 64'd32);
    check("b2b_first", {hi, lo}, 64'd4);
    operand1 = 32'd6;
    operand2 = 32'd7;
    tick();
    start = 1'b0;
    check("b2b_busy_again", {63'd0, busy}, 64'd1);
    wait_done(n);
    check("b2b_second_lat", 64'(n), 64'd32);
    check("b2b_second", {hi, lo}, 64'd42);
    tick();

    // reset mid-operation
    d0 = dut_done_cnt;
    issue(32'h12345678, 32'h10);
    repeat (15) tick();
    reset = 1'b0;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_flags", {61'd0, busy, stall, done}, 64'd0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("midrst_no_done", 64'(dut_done_cnt - d0), 64'd0);
    mult_lit("after_rst_2x3", 32'd2, 32'd3, 64'd6);

    // randomized multiplies with random idle gaps
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 0) b = 32'hFFFFFFFF;
      issue(a, b);
      wait_done(n);
      check("rand_prod", {hi, lo}, smul(a, b));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
